// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one Sysbus request/response channel between fetch and data requesters,
// one 64-byte line at a time. Define SYSBUS_ARB_FIXED_PRIO_EN for fixed data-first priority.
module sysbus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int TAG_W  = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_req_valid,
  input  logic [ADDR_W-1:0]       f_req_addr,
  output logic                    f_req_ready,
  output logic                    f_resp_valid,
  output logic [DATA_W-1:0]       f_resp_data,
  output logic                    f_resp_last,
  input  logic                    m_req_valid,
  input  logic                    m_req_write,
  input  logic [ADDR_W-1:0]       m_req_addr,
  input  logic [BEATS*DATA_W-1:0] m_req_wdata,
  output logic                    m_req_ready,
  output logic                    m_resp_valid,
  output logic [DATA_W-1:0]       m_resp_data,
  output logic                    m_resp_last,
  output logic                    bus_reqcyc,
  output logic [DATA_W-1:0]       bus_req,
  output logic [TAG_W-1:0]        bus_reqtag,
  input  logic                    bus_reqack,
  input  logic                    bus_respcyc,
  input  logic [DATA_W-1:0]       bus_resp,
  input  logic [TAG_W-1:0]        bus_resptag,
  output logic                    bus_respack
);

  localparam int LINE_LSB = 6;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RRESP} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             beat_cnt;
  logic                         owner_p0;
  logic                         write_p0;
  logic [ADDR_W-LINE_LSB-1:0]   addr_p0;
  logic [BEATS*DATA_W-1:0]      wdata_p0;

  logic grant_any;
  logic grant_data;
  logic resp_hit;
  logic wr_last_ack;
  logic unused_bits;

  // Arbitration: decided combinationally in IDLE so the ready pulse lands in the request cycle
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
  assign grant_data = m_req_valid;
`else
  logic last_grant;

  assign grant_data = m_req_valid && (!f_req_valid || (last_grant == OWN_FETCH));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_DATA;
    end else if (grant_any) begin
      last_grant <= grant_data;
    end
  end
`endif

  assign grant_any   = (state == IDLE) && !reset && (f_req_valid || m_req_valid);
  assign f_req_ready = grant_any && !grant_data;
  assign m_req_ready = grant_any && grant_data;

  // Response routing: beats only count when they belong to the transaction in flight
  assign resp_hit    = (state == RRESP) && !reset && bus_respcyc && (bus_resptag[0] == owner_p0);
  assign wr_last_ack = (state == WDATA) && !reset && bus_reqack && (beat_cnt == LAST_BEAT);

  assign f_resp_valid = resp_hit && (owner_p0 == OWN_FETCH);
  assign m_resp_valid = resp_hit && (owner_p0 == OWN_DATA);
  assign f_resp_data  = f_resp_valid ? bus_resp : '0;
  assign m_resp_data  = m_resp_valid ? bus_resp : '0;
  assign f_resp_last  = f_resp_valid && (beat_cnt == LAST_BEAT);
  assign m_resp_last  = (m_resp_valid && (beat_cnt == LAST_BEAT)) || wr_last_ack;
  assign bus_respack  = bus_respcyc;

  assign unused_bits = ^{f_req_addr[LINE_LSB-1:0], m_req_addr[LINE_LSB-1:0],
                         bus_resptag[TAG_W-1:1]};

  always_comb begin
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    if (!reset && (state == ADDR || state == WDATA)) begin
      bus_reqcyc = 1'b1;
      bus_reqtag = TAG_W'({~write_p0, 4'b0001, {(TAG_W-6){1'b0}}, owner_p0});
      if (state == ADDR) begin
        bus_req = DATA_W'({addr_p0, {LINE_LSB{1'b0}}});
      end else begin
        bus_req = wdata_p0[int'(beat_cnt)*DATA_W +: DATA_W];
      end
    end
  end

  // Request capture: data-path registers, loaded only on a grant
  always_ff @(posedge clk) begin
    if (grant_any) begin
      addr_p0  <= grant_data ? m_req_addr[ADDR_W-1:LINE_LSB] : f_req_addr[ADDR_W-1:LINE_LSB];
      write_p0 <= grant_data && m_req_write;
      wdata_p0 <= m_req_wdata;
    end
  end

  // Transaction FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      owner_p0 <= OWN_FETCH;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state    <= ADDR;
            owner_p0 <= grant_data;
            beat_cnt <= '0;
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            state    <= write_p0 ? WDATA : RRESP;
            beat_cnt <= '0;
          end
        end
        WDATA: begin
          if (bus_reqack) begin
            if (beat_cnt == LAST_BEAT) state <= IDLE;
            else beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        RRESP: begin
          if (resp_hit) begin
            if (beat_cnt == LAST_BEAT) state <= IDLE;
            else beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
